// File: rtl/pwm_multi_gen.sv
// Multi-generator PWM core: per-generator prescaler and edge/centre counter
// with period, duty and mode double-buffered to period boundaries, plus a
// registered pin mux with enable, static level and polarity control.
module pwm_multi_gen #(
  parameter int unsigned N_GEN = 2,
  parameter int unsigned N_CH  = 2,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_GEN-1:0]         gen_en,
  input  logic [N_GEN-1:0]         gen_center,
  input  logic [N_GEN*DIV_W-1:0]   gen_div,
  input  logic [N_GEN*CNT_W-1:0]   gen_period,
  input  logic [N_GEN*N_CH*CNT_W-1:0] duty,
  input  logic [N_OUT-1:0]         en_out,
  input  logic [N_OUT-1:0]         en_pwm_out,
  input  logic [N_OUT*SEL_W-1:0]   out_sel,
  input  logic [N_OUT-1:0]         invert,
  output logic [N_GEN-1:0]         gen_sync,
  output logic [N_OUT-1:0]         out
);

  localparam int unsigned N_SRC = N_GEN * N_CH;
  localparam int unsigned DCW   = 1 << DIV_W;

  logic [DCW-1:0]   div_cnt_q  [N_GEN];
  logic [DCW-1:0]   div_cnt_d  [N_GEN];
  logic [CNT_W-1:0] cnt_q      [N_GEN];
  logic [CNT_W-1:0] cnt_d      [N_GEN];
  logic [CNT_W-1:0] p_act_q    [N_GEN];
  logic [CNT_W-1:0] p_act_d    [N_GEN];
  logic [CNT_W-1:0] duty_act_q [N_SRC];
  logic [CNT_W-1:0] duty_act_d [N_SRC];
  logic [N_GEN-1:0] dir_q, dir_d;       // 1 = counting down
  logic [N_GEN-1:0] center_q, center_d;
  logic [N_GEN-1:0] sync_q, sync_d;
  logic [N_SRC-1:0] pwm;
  logic [N_OUT-1:0] out_q, out_d;

  // Prescaler, counter sequencing and shadow capture for every generator
  always_comb begin
    logic [DCW-1:0]   thr;
    logic [CNT_W-1:0] p;
    logic             tick;
    logic             bnd;
    logic             load;
    dir_d    = dir_q;
    center_d = center_q;
    sync_d   = '0;
    for (int unsigned s = 0; s < N_SRC; s++) duty_act_d[s] = duty_act_q[s];
    for (int unsigned g = 0; g < N_GEN; g++) begin
      div_cnt_d[g] = div_cnt_q[g];
      cnt_d[g]     = cnt_q[g];
      p_act_d[g]   = p_act_q[g];
      load         = 1'b0;
      // ">=" keeps a mid-run reduction of the divider from wrapping div_cnt
      thr  = (DCW'(1) << gen_div[g*DIV_W +: DIV_W]) - DCW'(1);
      tick = (div_cnt_q[g] >= thr);
      p    = p_act_q[g];
      if (center_q[g])
        bnd = (dir_q[g] && (cnt_q[g] <= CNT_W'(1))) ||
              (!dir_q[g] && (cnt_q[g] >= p) && (p <= CNT_W'(1)));
      else
        bnd = (cnt_q[g] >= p);

      if (!gen_en[g]) begin
        div_cnt_d[g] = '0;
        cnt_d[g]     = '0;
        dir_d[g]     = 1'b0;
        load         = 1'b1;
      end else if (tick) begin
        div_cnt_d[g] = '0;
        if (bnd) begin
          cnt_d[g]  = '0;
          dir_d[g]  = 1'b0;
          load      = 1'b1;
          sync_d[g] = 1'b1;
        end else if (!center_q[g]) begin
          cnt_d[g] = cnt_q[g] + CNT_W'(1);
        end else if (!dir_q[g]) begin
          if (cnt_q[g] >= p) begin
            dir_d[g] = 1'b1;
            cnt_d[g] = cnt_q[g] - CNT_W'(1);
          end else begin
            cnt_d[g] = cnt_q[g] + CNT_W'(1);
          end
        end else begin
          cnt_d[g] = cnt_q[g] - CNT_W'(1);
        end
      end else begin
        div_cnt_d[g] = div_cnt_q[g] + DCW'(1);
      end

      if (load) begin
        p_act_d[g]  = gen_period[g*CNT_W +: CNT_W];
        center_d[g] = gen_center[g];
        for (int unsigned c = 0; c < N_CH; c++)
          duty_act_d[g*N_CH+c] = duty[(g*N_CH+c)*CNT_W +: CNT_W];
      end
    end
  end

  // Duty compare per source, gated by its generator enable
  always_comb begin
    pwm = '0;
    for (int unsigned g = 0; g < N_GEN; g++)
      for (int unsigned c = 0; c < N_CH; c++)
        pwm[g*N_CH+c] = gen_en[g] & (cnt_q[g] < duty_act_q[g*N_CH+c]);
  end

  // Pin mux: out-of-range selects fall through to the inactive level
  always_comb begin
    logic [SEL_W-1:0] sel;
    logic             src;
    out_d = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      sel = out_sel[i*SEL_W +: SEL_W];
      src = 1'b0;
      for (int unsigned s = 0; s < N_SRC; s++)
        if (sel == SEL_W'(s)) src = pwm[s];
      if (!en_out[i])          out_d[i] = invert[i];
      else if (!en_pwm_out[i]) out_d[i] = ~invert[i];
      else                     out_d[i] = src ^ invert[i];
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned g = 0; g < N_GEN; g++) begin
        div_cnt_q[g] <= '0;
        cnt_q[g]     <= '0;
        p_act_q[g]   <= '0;
      end
      for (int unsigned s = 0; s < N_SRC; s++) duty_act_q[s] <= '0;
      dir_q    <= '0;
      center_q <= '0;
      sync_q   <= '0;
      out_q    <= '0;
    end else begin
      for (int unsigned g = 0; g < N_GEN; g++) begin
        div_cnt_q[g] <= div_cnt_d[g];
        cnt_q[g]     <= cnt_d[g];
        p_act_q[g]   <= p_act_d[g];
      end
      for (int unsigned s = 0; s < N_SRC; s++) duty_act_q[s] <= duty_act_d[s];
      dir_q    <= dir_d;
      center_q <= center_d;
      sync_q   <= sync_d;
      out_q    <= out_d;
    end
  end

  assign gen_sync = sync_q;
  assign out      = out_q;

endmodule
